// File: rtl/vga_scanout.sv
// vga_scanout
// -----------------------------------------------------------------------------
// Parametrised VGA scan-out engine. It generates horizontal and vertical timing
// for any mode and fetches pixels from an external synchronous frame-buffer RAM
// by linear address. The timing flags are delayed to match the RAM read latency,
// so pixel data, syncs and the display-enable flag leave the block on the same
// cycle.
//
// Optional feature, compiled in with `define VGA_TEST_PATTERN_EN:
//   When test_mode=1, eight vertical colour bars replace the RAM data and the
//   frame-buffer read strobe is held low. Without the macro, test_mode is
//   ignored and the pattern logic is absent.
//
// Ports:
//   clock       in   pixel clock; all logic on the rising edge
//   reset_n     in   asynchronous, active-low reset
//   enable      in   run timing; low parks the engine at (0,0)
//   test_mode   in   select the internal colour bars (test-pattern builds only)
//   fb_rd_en    out  frame-buffer read strobe
//   fb_addr     out  linear pixel address, y*H_ACTIVE + x
//   fb_rd_data  in   RAM data, valid RD_LAT cycles after fb_rd_en
//   vga_pixel   out  pixel value; 0 outside the active area
//   hsync_out   out  horizontal sync, active level SYNC_POL
//   vsync_out   out  vertical sync, active level SYNC_POL
//   in_display  out  output pixel lies in the active area
//   frame_start out  one-cycle pulse with output pixel (0,0)
//
// RD_LAT must be in 1..4. H_ACTIVE must be at least 8 so that each colour bar
// is at least one pixel wide.
// -----------------------------------------------------------------------------
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int PIXEL_W  = 3,
  parameter int RD_LAT   = 1,
  parameter bit SYNC_POL = 1'b0,
  parameter int AW       = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               test_mode,
  output logic               fb_rd_en,
  output logic [AW-1:0]      fb_addr,
  input  logic [PIXEL_W-1:0] fb_rd_data,
  output logic [PIXEL_W-1:0] vga_pixel,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               in_display,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT      = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_FIRST   = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] HS_LAST    = XW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT      = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_FIRST   = YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] VS_LAST    = YW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(H_ACTIVE * V_ACTIVE - 1);

`ifdef VGA_TEST_PATTERN_EN
  localparam int            BAR_W    = H_ACTIVE / 8;
  localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);
`endif

  // Per-pixel flags that travel down the latency-matching delay line.
  // hsync/vsync here are logical "asserted" flags; polarity is applied at the pins.
  typedef struct packed {
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          first;
`ifdef VGA_TEST_PATTERN_EN
    logic          pattern;
    logic [XW-1:0] bar;
`endif
  } stage_t;

  logic          running;
  logic [XW-1:0] count_x, next_x;
  logic [YW-1:0] count_y, next_y;
  logic [AW-1:0] next_addr;
  logic          next_rd_en;
  stage_t        stage0, stage0_next;
  stage_t        delay_q [RD_LAT];
  stage_t        delayed;
  logic [PIXEL_W-1:0] pixel_mux;

`ifdef VGA_TEST_PATTERN_EN
  logic [XW-1:0] bar_pos, next_bar_pos;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // Next counter values. The first enabled edge after reset or a park only
  // arms 'running' and leaves the counters at (0,0), so every run starts there.
  always_comb begin
    next_x = '0;
    next_y = '0;
    if (enable && running) begin
      if (count_x == X_LAST) begin
        next_x = '0;
        next_y = (count_y == Y_LAST) ? '0 : count_y + 1'b1;
      end else begin
        next_x = count_x + 1'b1;
        next_y = count_y;
      end
    end
  end

  // The address is a running counter: it advances after every active pixel and
  // holds through blanking, so it already points at the next line's first pixel.
  always_comb begin
    next_addr = '0;
    if (enable && running) begin
      next_addr = fb_addr;
      if (stage0.active) begin
        next_addr = (fb_addr == ADDR_LAST) ? '0 : fb_addr + 1'b1;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Bar index tracks count_x / BAR_W incrementally instead of dividing.
  always_comb begin
    next_bar_pos     = '0;
    stage0_next.bar  = '0;
    if (enable && running && (count_x != X_LAST)) begin
      if (bar_pos == BAR_LAST) begin
        next_bar_pos    = '0;
        stage0_next.bar = stage0.bar + 1'b1;
      end else begin
        next_bar_pos    = bar_pos + 1'b1;
        stage0_next.bar = stage0.bar;
      end
    end
  end
`endif

  // Stage-0 flags are computed from the next counter values and registered,
  // so they sit on the same cycle as the counters they describe.
  always_comb begin
    stage0_next.active  = 1'b0;
    stage0_next.hsync   = 1'b0;
    stage0_next.vsync   = 1'b0;
    stage0_next.first   = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    stage0_next.pattern = 1'b0;
`endif
    if (enable) begin
      stage0_next.active  = (next_x < X_ACT) && (next_y < Y_ACT);
      stage0_next.hsync   = (next_x >= HS_FIRST) && (next_x <= HS_LAST);
      stage0_next.vsync   = (next_y >= VS_FIRST) && (next_y <= VS_LAST);
      stage0_next.first   = (next_x == '0) && (next_y == '0);
`ifdef VGA_TEST_PATTERN_EN
      stage0_next.pattern = test_mode;
`endif
    end
`ifdef VGA_TEST_PATTERN_EN
    next_rd_en = stage0_next.active && !stage0_next.pattern;
`else
    next_rd_en = stage0_next.active;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running  <= 1'b0;
      count_x  <= '0;
      count_y  <= '0;
      fb_addr  <= '0;
      fb_rd_en <= 1'b0;
      stage0   <= '0;
`ifdef VGA_TEST_PATTERN_EN
      bar_pos  <= '0;
`endif
    end else begin
      running  <= enable;
      count_x  <= next_x;
      count_y  <= next_y;
      fb_addr  <= next_addr;
      fb_rd_en <= next_rd_en;
      stage0   <= stage0_next;
`ifdef VGA_TEST_PATTERN_EN
      bar_pos  <= next_bar_pos;
`endif
    end
  end

  // RD_LAT-deep delay line: its tail lines up with the RAM data for the same pixel.
  // When parked, idle flags shift in, so outputs drain to reset values naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        delay_q[i] <= '0;
      end
    end else begin
      delay_q[0] <= stage0;
      for (int i = 1; i < RD_LAT; i++) begin
        delay_q[i] <= delay_q[i-1];
      end
    end
  end

  assign delayed = delay_q[RD_LAT-1];

  always_comb begin
    pixel_mux = '0;
    if (delayed.active) begin
`ifdef VGA_TEST_PATTERN_EN
      pixel_mux = delayed.pattern ? PIXEL_W'(delayed.bar) : fb_rd_data;
`else
      pixel_mux = fb_rd_data;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_pixel   <= '0;
      hsync_out   <= ~SYNC_POL;
      vsync_out   <= ~SYNC_POL;
      in_display  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_pixel   <= pixel_mux;
      hsync_out   <= delayed.hsync ? SYNC_POL : ~SYNC_POL;
      vsync_out   <= delayed.vsync ? SYNC_POL : ~SYNC_POL;
      in_display  <= delayed.active;
      frame_start <= delayed.first;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
// -----------------------------------------------------------------------------
// Self-checking bench for vga_scanout using a small video mode so several whole
// frames fit in a short run. A frame-position model (plain arithmetic on a pixel
// counter) predicts every output; a two-stage RAM model returns fb_addr[2:0].
// Build with VGA_TEST_PATTERN_EN defined to exercise the colour bars.
// -----------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int H_ACTIVE = 16;
  localparam int H_FRONT  = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BACK   = 3;
  localparam int V_ACTIVE = 8;
  localparam int V_FRONT  = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 2;
  localparam int PIXEL_W  = 3;
  localparam int RD_LAT   = 2;
  localparam int AW       = $clog2(H_ACTIVE * V_ACTIVE);
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               test_mode;
  logic               fb_rd_en;
  logic [AW-1:0]      fb_addr;
  logic [PIXEL_W-1:0] fb_rd_data;
  logic [PIXEL_W-1:0] vga_pixel;
  logic               hsync_out;
  logic               vsync_out;
  logic               in_display;
  logic               frame_start;

  vga_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .PIXEL_W(PIXEL_W), .RD_LAT(RD_LAT), .SYNC_POL(1'b0), .AW(AW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .test_mode(test_mode),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rd_data(fb_rd_data),
    .vga_pixel(vga_pixel), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .in_display(in_display), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // Frame-buffer RAM stand-in: two-cycle read latency, data = low address bits.
  logic [2:0] ram_q1 = '0;
  logic [2:0] ram_q2 = '0;
  logic       force_seven = 1'b0;
  always @(posedge clock) begin
    ram_q1 <= fb_addr[2:0];
    ram_q2 <= ram_q1;
  end
  assign fb_rd_data = force_seven ? 3'b111 : ram_q2;

  // Model of one pixel slot as seen at the counter stage.
  typedef struct {
    bit valid;
    bit active;
    bit hs;
    bit vs;
    bit first;
    bit pattern;
    int x;
    int y;
  } pos_t;

  pos_t hist[$];
  pos_t cur;
  pos_t out_exp;
  int   exp_pixel;
  bit   run;
  int   p;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit   measure_on = 1'b0;
  bit   hs_prev;
  int   hs_len, vs_len, hs_fall_cyc, fs_cyc;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic pos_t idlePos();
    pos_t s;
    s.valid = 0; s.active = 0; s.hs = 0; s.vs = 0; s.first = 0; s.pattern = 0;
    s.x = 0; s.y = 0;
    return s;
  endfunction

  task automatic modelReset();
    run = 0;
    p   = 0;
    hist.delete();
    for (int i = 0; i < RD_LAT + 1; i++) hist.push_back(idlePos());
    cur     = idlePos();
    out_exp = idlePos();
    exp_pixel = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic modelEdge();
    pos_t s;
    if (!enable) begin
      run = 0; p = 0;
    end else if (!run) begin
      run = 1; p = 0;
    end else begin
      p = (p + 1) % FRAME;
    end
    s = idlePos();
    if (run) begin
      s.valid  = 1;
      s.x      = p % H_TOTAL;
      s.y      = p / H_TOTAL;
      s.active = (s.x < H_ACTIVE) && (s.y < V_ACTIVE);
      s.hs     = (s.x >= H_ACTIVE + H_FRONT) && (s.x < H_ACTIVE + H_FRONT + H_SYNC);
      s.vs     = (s.y >= V_ACTIVE + V_FRONT) && (s.y < V_ACTIVE + V_FRONT + V_SYNC);
      s.first  = (p == 0);
`ifdef VGA_TEST_PATTERN_EN
      s.pattern = test_mode;
`endif
    end
    cur = s;
    hist.push_back(s);
    out_exp = hist.pop_front();
    if (!out_exp.active)      exp_pixel = 0;
    else if (out_exp.pattern) exp_pixel = (out_exp.x / (H_ACTIVE / 8)) % 8;
    else if (force_seven)     exp_pixel = 7;
    else                      exp_pixel = (out_exp.y * H_ACTIVE + out_exp.x) % 8;
  endtask

  task automatic compareCycle();
    cyc++;
    checkOutput("vga_pixel",   vga_pixel,   exp_pixel);
    checkOutput("in_display",  in_display,  out_exp.active);
    checkOutput("hsync_out",   hsync_out,   out_exp.hs ? 0 : 1);
    checkOutput("vsync_out",   vsync_out,   out_exp.vs ? 0 : 1);
    checkOutput("frame_start", frame_start, out_exp.first);
    checkOutput("fb_rd_en",    fb_rd_en,    cur.active && !cur.pattern);
    if (cur.active)      checkOutput("fb_addr", fb_addr, cur.y * H_ACTIVE + cur.x);
    else if (!cur.valid) checkOutput("fb_addr_parked", fb_addr, 0);
    if (force_seven && !in_display) checkOutput("blank_pixel", vga_pixel, 0);
    if (measure_on) begin
      if (hsync_out == 1'b0) hs_len++;
      else if (hs_len > 0) begin checkOutput("hsync_width", hs_len, H_SYNC); hs_len = 0; end
      if (vsync_out == 1'b0) vs_len++;
      else if (vs_len > 0) begin checkOutput("vsync_width", vs_len, V_SYNC * H_TOTAL); vs_len = 0; end
      if (hsync_out == 1'b0 && hs_prev == 1'b1) begin
        if (hs_fall_cyc >= 0) checkOutput("hsync_period", cyc - hs_fall_cyc, H_TOTAL);
        hs_fall_cyc = cyc;
      end
      if (frame_start) begin
        if (fs_cyc >= 0) checkOutput("frame_period", cyc - fs_cyc, FRAME);
        fs_cyc = cyc;
      end
    end
    hs_prev = hsync_out;
  endtask

  // Drive one cycle of inputs, let the edge happen, then check on the falling edge.
  task automatic applyStimulus(input bit en, input bit tm);
    enable    = en;
    test_mode = tm;
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    compareCycle();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pixel"},  vga_pixel,   0);
    checkOutput({tag, "_hsync"},  hsync_out,   1);
    checkOutput({tag, "_vsync"},  vsync_out,   1);
    checkOutput({tag, "_disp"},   in_display,  0);
    checkOutput({tag, "_addr"},   fb_addr,     0);
    checkOutput({tag, "_rd_en"},  fb_rd_en,    0);
    checkOutput({tag, "_fstart"}, frame_start, 0);
  endtask

  initial begin
    int  off_left;
    bit  tm;
    int  first_fs;

    reset_n = 1'b0;
    enable  = 1'b0;
    test_mode = 1'b0;
    modelReset();
    repeat (3) @(negedge clock);
    checkResetValues("reset");
    reset_n = 1'b1;

    // Steady run: three frames with sync widths, periods and frame spacing measured.
    hs_prev = 1'b1; hs_len = 0; vs_len = 0; hs_fall_cyc = -1; fs_cyc = -1;
    measure_on = 1'b1;
    for (int i = 0; i < 3 * FRAME + 50; i++) applyStimulus(1'b1, 1'b0);
    measure_on = 1'b0;

    // Random enable drops and random test_mode changes.
    off_left = 0;
    tm = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (off_left > 0) off_left--;
      else if ($urandom_range(0, 149) == 0) off_left = $urandom_range(1, 6);
      if ($urandom_range(0, 39) == 0) tm = ~tm;
      applyStimulus(off_left == 0, tm);
    end

    // Constant all-ones RAM data: blanking must still read 0.
    force_seven = 1'b1;
    for (int i = 0; i < FRAME + 20; i++) applyStimulus(1'b1, 1'b0);
    force_seven = 1'b0;

    // Reach the middle of a visible line, then reset asynchronously.
    for (int i = 0; i < 2 * FRAME && in_display != 1'b1; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("wait_display", in_display, 1);
    for (int i = 0; i < H_ACTIVE / 2; i++) applyStimulus(1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 checkResetValues("midreset");
    repeat (2) @(negedge clock);
    modelReset();
    reset_n = 1'b1;

    // After release the first frame_start follows the counters' arrival at (0,0)
    // (first enabled edge) by RD_LAT+1 edges.
    first_fs = -1;
    for (int i = 1; i <= FRAME + 40; i++) begin
      applyStimulus(1'b1, $urandom_range(0, 1) == 1);
      if (frame_start && first_fs < 0) first_fs = i;
    end
    checkOutput("first_frame_start", first_fs, 1 + RD_LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
